// File: rtl/morse_symbol_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_symbol_packer_pkg
//  Description : Shared definitions for the Morse symbol path. Holds the
//                2-bit symbol codes used by player1, player2 and translator,
//                the RAM word/address widths, the press FSM state type and
//                the LEDG thermometer helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package morse_symbol_packer_pkg;

  localparam int WORD_W = 10;
  localparam int ADDR_W = 4;

  localparam logic [1:0] SYM_EMPTY = 2'b00;
  localparam logic [1:0] SYM_DOT   = 2'b01;
  localparam logic [1:0] SYM_DASH  = 2'b11;

  typedef enum logic [0:0] {
    PS_IDLE  = 1'b0,
    PS_PRESS = 1'b1
  } press_state_e;

  // Press length as a 3-LED thermometer; anything from 3 ticks up lights all.
  function automatic logic [2:0] thermo3(input logic [2:0] len);
    logic [2:0] vis;
    case (len)
      3'd0:    vis = 3'b000;
      3'd1:    vis = 3'b001;
      3'd2:    vis = 3'b011;
      default: vis = 3'b111;
    endcase
    return vis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_symbol_packer_press_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : press_classifier
//  Description : Times a morse key press on the 1 Hz tick and classifies it
//                as a dot or a dash on release.
//  Ports       : clock_1hz  - 1 Hz tick clock
//                resetn     - synchronous active-low reset
//                enable     - player-1 turn; when low the press is abandoned
//                key_n      - morse key, active-low
//                sym_valid  - high in the release cycle of a press
//                sym_code   - SYM_DOT or SYM_DASH, valid with sym_valid
//                press_vis  - thermometer of the running press length
//  Revision    : 1.0 - initial release
// ============================================================================
module press_classifier
  import morse_symbol_packer_pkg::*;
#(
  parameter int DOT_MAX = 2
) (
  input  logic       clock_1hz,
  input  logic       resetn,
  input  logic       enable,
  input  logic       key_n,
  output logic       sym_valid,
  output logic [1:0] sym_code,
  output logic [2:0] press_vis
);

  press_state_e state_q;
  logic [2:0]   press_len_q;
  logic [2:0]   press_vis_q;
  logic         key_prev_q;
  logic [2:0]   len_inc;

  always_comb begin
    len_inc = (press_len_q == 3'd7) ? 3'd7 : press_len_q + 3'd1;
  end

  // Release is decoded from the registered state and the live key so the
  // packer can append the symbol on the very edge that samples the release.
  always_comb begin
    sym_valid = enable && (state_q == PS_PRESS) && key_n;
    sym_code  = (int'(press_len_q) <= DOT_MAX) ? SYM_DOT : SYM_DASH;
  end

  // A press only starts on a sampled falling edge of key_n. The edge register
  // clears to "pressed" on reset, so a key held through reset is discarded,
  // and it keeps tracking while disabled so enable rising is not an edge.
  always_ff @(posedge clock_1hz) begin
    if (!resetn) begin
      state_q     <= PS_IDLE;
      press_len_q <= 3'd0;
      press_vis_q <= 3'd0;
      key_prev_q  <= 1'b0;
    end else begin
      key_prev_q <= key_n;
      if (!enable) begin
        state_q     <= PS_IDLE;
        press_len_q <= 3'd0;
        press_vis_q <= 3'd0;
      end else begin
        case (state_q)
          PS_IDLE: begin
            if (!key_n && key_prev_q) begin
              state_q     <= PS_PRESS;
              press_len_q <= 3'd1;
              press_vis_q <= thermo3(3'd1);
            end
          end
          PS_PRESS: begin
            if (!key_n) begin
              press_len_q <= len_inc;
              press_vis_q <= thermo3(len_inc);
            end else begin
              state_q     <= PS_IDLE;
              press_len_q <= 3'd0;
              press_vis_q <= 3'd0;
            end
          end
          default: begin
            state_q     <= PS_IDLE;
            press_len_q <= 3'd0;
            press_vis_q <= 3'd0;
          end
        endcase
      end
    end
  end

  assign press_vis = press_vis_q;

endmodule
`default_nettype wire

// File: rtl/morse_symbol_packer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_symbol_packer
//  Description : Player-1 front end. Packs classified key presses into a
//                10-bit word (symbol i in bits [2i+1:2i]) and writes the word
//                to ram32x10 on a falling edge of next_n.
//  Ports       : clock_1hz  - 1 Hz tick clock
//                resetn     - synchronous active-low reset
//                enable     - player-1 turn
//                key_n      - morse key, active-low
//                next_n     - commit request, active-low
//                wr_en      - one-cycle RAM write strobe
//                wr_addr    - RAM address of the current/next commit
//                wr_data    - packed word of the current commit
//                sym_count  - symbols in the word under construction
//                press_vis  - LEDG press-length thermometer
//                overflow   - sticky: a symbol was dropped (word full)
//                mem_full   - all DEPTH words written
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_symbol_packer
  import morse_symbol_packer_pkg::*;
#(
  parameter int DOT_MAX  = 2,
  parameter int MAX_SYMS = 5,
  parameter int DEPTH    = 16
) (
  input  logic              clock_1hz,
  input  logic              resetn,
  input  logic              enable,
  input  logic              key_n,
  input  logic              next_n,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic [2:0]        sym_count,
  output logic [2:0]        press_vis,
  output logic              overflow,
  output logic              mem_full
);

  localparam logic [2:0]        MAX_CNT   = 3'(MAX_SYMS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic              sym_valid;
  logic [1:0]        sym_code;

  logic [WORD_W-1:0] word_q,     word_d;
  logic [2:0]        count_q,    count_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic              mem_full_q, mem_full_d;
  logic              wr_en_q,    wr_en_d;
  logic [WORD_W-1:0] wr_data_q,  wr_data_d;
  logic              next_prev_q;

  logic [WORD_W-1:0] word_base;
  logic [2:0]        count_base;
  logic              commit_fire;

  press_classifier #(
    .DOT_MAX (DOT_MAX)
  ) u_press_classifier (
    .clock_1hz (clock_1hz),
    .resetn    (resetn),
    .enable    (enable),
    .key_n     (key_n),
    .sym_valid (sym_valid),
    .sym_code  (sym_code),
    .press_vis (press_vis)
  );

  always_comb begin
    // The strobe cycle retires the committed word, so anything classified
    // during it is packed into an already-cleared word.
    word_base  = wr_en_q ? '0   : word_q;
    count_base = wr_en_q ? 3'd0 : count_q;

    word_d     = word_base;
    count_d    = count_base;
    overflow_d = wr_en_q ? 1'b0 : overflow_q;

    if (sym_valid) begin
      if (count_base == MAX_CNT) begin
        overflow_d = 1'b1;
      end else begin
        for (int i = 0; i < MAX_SYMS; i++) begin
          if (count_base == 3'(i)) begin
            word_d[2*i +: 2] = sym_code;
          end
        end
        count_d = count_base + 3'd1;
      end
    end

    // Uses the post-append count so a release on the commit edge is included.
    commit_fire = enable && !next_n && next_prev_q && (count_d != 3'd0) &&
                  !mem_full_q && !wr_en_q;

    wr_en_d   = commit_fire;
    wr_data_d = commit_fire ? word_d : wr_data_q;

    addr_d     = addr_q;
    mem_full_d = mem_full_q;
    if (wr_en_q) begin
      if (addr_q == LAST_ADDR) begin
        mem_full_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_1hz) begin
    if (!resetn) begin
      word_q      <= '0;
      count_q     <= 3'd0;
      overflow_q  <= 1'b0;
      addr_q      <= '0;
      mem_full_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      next_prev_q <= 1'b0;
    end else begin
      word_q      <= word_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      addr_q      <= addr_d;
      mem_full_q  <= mem_full_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      next_prev_q <= next_n;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = addr_q;
  assign wr_data   = wr_data_q;
  assign sym_count = count_q;
  assign overflow  = overflow_q;
  assign mem_full  = mem_full_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_symbol_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_symbol_packer
//  Description : Self-checking bench for morse_symbol_packer: a directed
//                vector table, hand sequences for the multi-cycle corners and
//                random stimulus against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_symbol_packer;
  import morse_symbol_packer_pkg::*;

  localparam int DOT_MAX  = 2;
  localparam int MAX_SYMS = 5;
  localparam int DEPTH    = 16;

  logic       clock_1hz = 1'b0;
  logic       resetn    = 1'b0;
  logic       enable    = 1'b0;
  logic       key_n     = 1'b1;
  logic       next_n    = 1'b1;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [9:0] wr_data;
  logic [2:0] sym_count;
  logic [2:0] press_vis;
  logic       overflow;
  logic       mem_full;

  int tests = 0;
  int fails = 0;
  int wr_pulses = 0;

  always #5 clock_1hz = ~clock_1hz;

  morse_symbol_packer #(
    .DOT_MAX  (DOT_MAX),
    .MAX_SYMS (MAX_SYMS),
    .DEPTH    (DEPTH)
  ) dut (
    .clock_1hz (clock_1hz),
    .resetn    (resetn),
    .enable    (enable),
    .key_n     (key_n),
    .next_n    (next_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .sym_count (sym_count),
    .press_vis (press_vis),
    .overflow  (overflow),
    .mem_full  (mem_full)
  );

  // ---------------- reference model (symbol queue + counters) --------------
  int m_len;          // ticks the key has been held, 0 when not pressing
  bit m_kprev, m_nprev;
  int m_syms[$];      // symbol codes of the word being keyed, first keyed first
  bit m_ovf, m_full, m_pend, m_wren;
  int m_addr, m_data;

  function automatic int m_pack();
    int w = 0;
    foreach (m_syms[i]) w += m_syms[i] << (2 * i);
    return w;
  endfunction

  function automatic int m_vis();
    if (m_len >= 3) return 7;
    if (m_len == 2) return 3;
    return m_len;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit key, input bit nxt);
    int sym;
    if (!rst) begin
      m_len = 0; m_kprev = 0; m_nprev = 0; m_syms.delete();
      m_ovf = 0; m_full = 0; m_pend = 0; m_wren = 0; m_addr = 0; m_data = 0;
      return;
    end
    m_wren = 0;
    sym    = -1;
    if (m_pend) begin
      m_syms.delete();
      m_ovf = 0;
      if (m_addr == DEPTH - 1) m_full = 1;
      else m_addr++;
      m_pend = 0;
    end
    if (!en) m_len = 0;
    else if (m_len > 0) begin
      if (!key) m_len = (m_len >= 7) ? 7 : m_len + 1;
      else begin
        sym   = (m_len <= DOT_MAX) ? int'(SYM_DOT) : int'(SYM_DASH);
        m_len = 0;
      end
    end else if (!key && m_kprev) m_len = 1;
    if (sym >= 0) begin
      if (m_syms.size() == MAX_SYMS) m_ovf = 1;
      else m_syms.push_back(sym);
    end
    if (en && !nxt && m_nprev && m_syms.size() > 0 && !m_full) begin
      m_wren = 1;
      m_data = m_pack();
      m_pend = 1;
    end
    m_kprev = key;
    m_nprev = nxt;
  endtask

  // ---------------- checking helpers ---------------------------------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_model();
    tests++;
    if (wr_en !== m_wren || int'(wr_addr) != m_addr || int'(wr_data) != m_data ||
        int'(sym_count) != m_syms.size() || int'(press_vis) != m_vis() ||
        overflow !== m_ovf || mem_full !== m_full) begin
      fails++;
      $display("FAIL model t=%0t: got wr_en=%0b addr=%0d data=%h cnt=%0d vis=%b ovf=%0b full=%0b; expected wr_en=%0b addr=%0d data=%h cnt=%0d vis=%b ovf=%0b full=%0b",
               $time, wr_en, wr_addr, wr_data, sym_count, press_vis, overflow, mem_full,
               m_wren, m_addr, m_data[9:0], m_syms.size(), m_vis(), m_ovf, m_full);
    end
  endtask

  // Apply inputs, let the DUT sample them, then check half a period later.
  task automatic tick(input bit rst, input bit en, input bit key, input bit nxt);
    resetn = rst; enable = en; key_n = key; next_n = nxt;
    @(posedge clock_1hz);
    model_step(rst, en, key, nxt);
    @(negedge clock_1hz);
    if (wr_en === 1'b1) wr_pulses++;
    check_model();
  endtask

  task automatic do_reset();
    tick(0, 1, 1, 1);
    tick(0, 1, 1, 1);
    tick(1, 1, 1, 1);
  endtask

  task automatic press(input int n);
    repeat (n) tick(1, 1, 0, 1);
    tick(1, 1, 1, 1);
  endtask

  task automatic commit();
    tick(1, 1, 1, 0);
    tick(1, 1, 1, 1);
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    bit rst, en, key, nxt;
    bit wr_en;
    int addr, data, cnt, vis;
    bit ovf, full;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input bit rst, input bit key, input bit nxt, input bit we,
                         input int addr, input int data, input int cnt, input int vis);
    vec_t v;
    v.rst = rst; v.en = 1'b1; v.key = key; v.nxt = nxt;
    v.wr_en = we; v.addr = addr; v.data = data; v.cnt = cnt; v.vis = vis;
    v.ovf = 1'b0; v.full = 1'b0;
    vq.push_back(v);
  endtask

  initial begin
    bit r, e, k, n;

    // reset, then 1-tick dot, 2-tick dot, 3-tick dash, commit
    //       rst key nxt we addr data    cnt vis
    add_vec(0, 1, 1, 0, 0, 0,       0, 0);
    add_vec(0, 1, 1, 0, 0, 0,       0, 0);
    add_vec(1, 1, 1, 0, 0, 0,       0, 0);
    add_vec(1, 0, 1, 0, 0, 0,       0, 1);
    add_vec(1, 1, 1, 0, 0, 0,       1, 0);
    add_vec(1, 0, 1, 0, 0, 0,       1, 1);
    add_vec(1, 0, 1, 0, 0, 0,       1, 3);
    add_vec(1, 1, 1, 0, 0, 0,       2, 0);
    add_vec(1, 0, 1, 0, 0, 0,       2, 1);
    add_vec(1, 0, 1, 0, 0, 0,       2, 3);
    add_vec(1, 0, 1, 0, 0, 0,       2, 7);
    add_vec(1, 1, 1, 0, 0, 0,       3, 0);
    add_vec(1, 1, 0, 1, 0, 10'h035, 3, 0);
    add_vec(1, 1, 0, 0, 1, 10'h035, 0, 0);
    add_vec(1, 1, 1, 0, 1, 10'h035, 0, 0);

    foreach (vq[i]) begin
      tick(vq[i].rst, vq[i].en, vq[i].key, vq[i].nxt);
      tests++;
      if (wr_en !== vq[i].wr_en || int'(wr_addr) != vq[i].addr || int'(wr_data) != vq[i].data ||
          int'(sym_count) != vq[i].cnt || int'(press_vis) != vq[i].vis ||
          overflow !== vq[i].ovf || mem_full !== vq[i].full) begin
        fails++;
        $display("FAIL vec%0d: got wr_en=%0b addr=%0d data=%h cnt=%0d vis=%b ovf=%0b full=%0b; expected wr_en=%0b addr=%0d data=%h cnt=%0d vis=%b ovf=%0b full=%0b",
                 i, wr_en, wr_addr, wr_data, sym_count, press_vis, overflow, mem_full,
                 vq[i].wr_en, vq[i].addr, vq[i].data, vq[i].cnt, vq[i].vis, vq[i].ovf, vq[i].full);
      end
    end

    // reset state, then idle ticks with no strobe
    do_reset();
    check("reset_addr", int'(wr_addr), 0);
    check("reset_data", int'(wr_data), 0);
    wr_pulses = 0;
    repeat (10) tick(1, 1, 1, 1);
    check("idle_no_wr", wr_pulses, 0);

    // overflow: six dots into a five-slot word
    do_reset();
    repeat (6) press(1);
    check("ovf_count", int'(sym_count), 5);
    check("ovf_flag", int'(overflow), 1);
    tick(1, 1, 1, 0);
    check("ovf_wr_en", int'(wr_en), 1);
    check("ovf_wr_data", int'(wr_data), 10'h155);
    tick(1, 1, 1, 1);
    check("ovf_cleared", int'(overflow), 0);
    check("ovf_cnt_cleared", int'(sym_count), 0);

    // empty commit, then a held next_n
    do_reset();
    wr_pulses = 0;
    commit();
    check("empty_commit_no_wr", wr_pulses, 0);
    check("empty_commit_addr", int'(wr_addr), 0);
    press(1);
    wr_pulses = 0;
    repeat (5) tick(1, 1, 1, 0);
    tick(1, 1, 1, 1);
    check("held_next_one_wr", wr_pulses, 1);
    check("held_next_addr", int'(wr_addr), 1);

    // dash released on the same edge that next_n falls
    do_reset();
    repeat (3) tick(1, 1, 0, 1);
    tick(1, 1, 1, 0);
    check("simul_wr_en", int'(wr_en), 1);
    check("simul_wr_data", int'(wr_data), 10'h003);
    check("simul_wr_addr", int'(wr_addr), 0);
    tick(1, 1, 1, 1);

    // fill all sixteen words
    do_reset();
    repeat (DEPTH) begin
      press(1);
      commit();
    end
    check("full_flag", int'(mem_full), 1);
    check("full_addr", int'(wr_addr), DEPTH - 1);
    wr_pulses = 0;
    press(1);
    commit();
    check("full_no_wr", wr_pulses, 0);
    check("full_addr_hold", int'(wr_addr), DEPTH - 1);

    // key activity while disabled is ignored
    do_reset();
    press(1);
    repeat (3) tick(1, 0, 0, 1);
    check("dis_count", int'(sym_count), 1);
    check("dis_vis", int'(press_vis), 0);
    tick(1, 1, 0, 1);
    check("en_rise_no_press", int'(press_vis), 0);
    tick(1, 1, 1, 1);
    check("en_rise_count", int'(sym_count), 1);

    // random traffic against the model
    do_reset();
    e = 1; k = 1; n = 1;
    for (int c = 0; c < 4000; c++) begin
      r = ($urandom_range(0, 149) != 0);
      if (e) e = ($urandom_range(0, 39) != 0);
      else   e = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) k = ~k;
      if ($urandom_range(0, 4) == 0) n = ~n;
      tick(r, e, k, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/morse_symbol_packer.md
Name: morse_symbol_packer

Overview:
- Player-1 front end that sits upstream of ram32x10. It turns raw key presses, sampled on clock_1hz, into dot/dash symbols.
- Packs up to 5 symbols into one 10-bit word, the same encoding player2 and translator consume.
- On a commit request it issues a single-cycle write strobe with address and data to the RAM.
- Also drives the LEDG press-length visual and the player-1 address for HEX2.

Parameters:
- DOT_MAX, 2, longest press in ticks still classified as a dot. Longer presses are dashes.
- MAX_SYMS, 5, symbols per word. Fixed by the 10-bit data width.
- DEPTH, 16, number of RAM words addressable by player 1.

Ports:
- clock_1hz  in  1  1 Hz tick clock.
- resetn  in  1  reset; synchronous, active-low.
- enable  in  1  high only during the S_P1TURN state. When low, all inputs are ignored.
- key_n  in  1  morse key, active-low (KEY[0]).
- next_n  in  1  commit-word request, active-low (KEY[1]).
- wr_en  out  1  one-cycle RAM write strobe.
- wr_addr  out  4  RAM address for the current commit.
- wr_data  out  10  packed word for the current commit.
- sym_count  out  3  symbols in the word under construction (0..5).
- press_vis  out  3  thermometer of the current press length, for LEDG[2:0].
- overflow  out  1  sticky: a symbol was dropped because the word was full.
- mem_full  out  1  all DEPTH words written.

Behaviour:
Reset and enable:
- On resetn=0 at a clock edge, all registers clear: wr_en=0, wr_addr=0, wr_data=0, sym_count=0, press_vis=0, overflow=0, mem_full=0. The press counter and edge registers also clear.
- Reset asserted mid-press discards that press.
- While enable=0: no wr_en, word/address/flags hold their values, the press counter clears, and both edge registers track their inputs so that no spurious edge fires when enable rises.

Symbol encoding:
- Symbol i occupies wr_data[2i+1:2i], with i=0 being the first symbol keyed.
- Codes: 00 = empty, 01 = dot, 11 = dash.

Press FSM (states IDLE, PRESS):
- IDLE: if key_n=0, go to PRESS with press_len=1.
- PRESS: while key_n=0, press_len increments, saturating at 7.
- PRESS to IDLE when key_n=1. That release cycle classifies the press: press_len ≤ DOT_MAX gives a dot, otherwise a dash.
- press_vis shows press_len as a thermometer, saturating at 3'b111, and reads 0 in IDLE.

Appending symbols:
- A classified symbol is written into slot sym_count, and sym_count increments.
- If sym_count=MAX_SYMS, the symbol is dropped and overflow is set. overflow clears only on reset or a successful commit.

Commit:
- Triggered when next_n is sampled 0 having been 1 on the previous edge (falling edge).
- If sym_count>0 and mem_full=0:
  - in the next cycle wr_en=1, wr_data is the packed word, and wr_addr is the current address;
  - the following cycle wr_en=0, the address increments, and the word and sym_count clear;
  - if the address was DEPTH-1, it stays there and mem_full is set.
- A commit with sym_count=0 is ignored: no strobe, no address change.
- A commit while mem_full=1 is ignored.
- Release and commit in the same cycle: the classified symbol is appended first and included in the written word.
- A new press during a commit cycle is accepted; its symbol lands in the cleared word.
- Holding next_n low produces only one commit.

Decomposition:
- Shared package holds:
  - symbol codes SYM_EMPTY=2'b00, SYM_DOT=2'b01, SYM_DASH=2'b11 (also used by player2 and translator);
  - WORD_W=10 and ADDR_W=4.
- One natural sub-module, press_classifier, containing the press FSM, press_len and press_vis. It outputs sym_valid and sym_code.
- The packing, address and commit logic stays in the top of this block.

Test Plan:
- Reset: hold resetn=0 for 2 ticks, then release → all outputs 0, with no wr_en for 10 idle ticks.
- Dot/dash: with DOT_MAX=2, press 1 tick, 2 ticks, 3 ticks, then commit → wr_en for 1 cycle with wr_addr=0, wr_data=10'b00_00_11_01_01; then wr_addr=1 and sym_count=0.
- Overflow: key 6 dots, then commit → sym_count saturates at 5, overflow=1, wr_data=10'b01_01_01_01_01; overflow clears after the commit.
- Empty commit and held next: commit with sym_count=0 → no wr_en. Then key 1 dot and hold next_n low for 5 ticks → exactly one wr_en.
- Simultaneous release and commit: dash released on the same edge next_n falls → wr_data=10'b00_00_00_00_11.
- mem_full and enable gating: 16 single-dot commits → mem_full=1 at wr_addr=15, and a 17th commit gives no wr_en. Separately, press key_n with enable=0 → sym_count unchanged and press_vis=0.
